serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 137 +++++++++++++
 tb/tb_serial_adder.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell iterated LSB first over WIDTH clocks.
// Result, carry-out and signed overflow are registered and flagged by done.

module serial_adder_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ci,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             fa_s, fa_c;
    logic [WIDTH-1:0] sum_nx;

    serial_adder_fa u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_c)
    );

    assign sum_nx = {fa_s, sum_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    carry_d = Ci;
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy    = 1'b1;
                sum_d   = sum_nx;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_c;
                cnt_d   = cnt_q + CW'(1);
                // carry_q here is the carry into the MSB
                if (cnt_q == CW'(WIDTH - 1)) begin
                    s_d     = sum_nx;
                    cout_d  = fa_c;
                    ovf_d   = carry_q ^ fa_c;
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign S    = s_q;
    assign Cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomised checks of serial_adder at WIDTH=8 and WIDTH=16.
// Each scenario task performs its own comparisons against hand values or a model.

module tb_serial_adder;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  A, B, S;
    logic        Ci, Cout, ovf, busy, done;

    logic        start16;
    logic [15:0] A16, B16, S16;
    logic        Ci16, Cout16, ovf16, busy16, done16;

    int checks;
    int fails;

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Ci    (Ci),
        .S     (S),
        .Cout  (Cout),
        .ovf   (ovf),
        .busy  (busy),
        .done  (done)
    );

    serial_adder #(.WIDTH(16)) dut16 (
        .clk   (clk),
        .rst   (rst),
        .start (start16),
        .A     (A16),
        .B     (B16),
        .Ci    (Ci16),
        .S     (S16),
        .Cout  (Cout16),
        .ovf   (ovf16),
        .busy  (busy16),
        .done  (done16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one 8-bit op; edges = edges from start edge to the edge sampling done.
    task automatic op8(input logic [7:0] a, input logic [7:0] b,
                       input logic ci, output logic [7:0] s,
                       output logic c, output logic o,
                       output int edges, output int both);
        logic d;
        @(negedge clk);
        A = a; B = b; Ci = ci; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; A = 8'h5A; B = 8'hC3; Ci = 1'b1;
        edges = 0;
        both = 0;
        s = 'x; c = 1'bx; o = 1'bx;
        d = 1'b0;
        while (!d && edges < 40) begin
            if (edges > 0) @(negedge clk);
            d = done;
            if (busy && done) both++;
            if (d) begin s = S; c = Cout; o = ovf; end
            @(posedge clk);
            edges++;
        end
        if (!d) edges = 999;
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b,
                        input logic ci, output logic [15:0] s,
                        output logic c, output logic o, output int edges);
        logic d;
        @(negedge clk);
        A16 = a; B16 = b; Ci16 = ci; start16 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start16 = 1'b0; A16 = 16'hDEAD; B16 = 16'hBEEF;
        edges = 0;
        s = 'x; c = 1'bx; o = 1'bx;
        d = 1'b0;
        while (!d && edges < 60) begin
            if (edges > 0) @(negedge clk);
            d = done16;
            if (d) begin s = S16; c = Cout16; o = ovf16; end
            @(posedge clk);
            edges++;
        end
        if (!d) edges = 999;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; A = '0; B = '0; Ci = 1'b0;
        start16 = 1'b0; A16 = '0; B16 = '0; Ci16 = 1'b0;
        #12;
        checks++;
        if ({S, Cout, ovf, busy, done} !== 12'h0) begin
            fails++;
            $display("FAIL reset_state: got S=%h C=%b V=%b busy=%b done=%b, want all 0",
                     S, Cout, ovf, busy, done);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_basic();
        logic [7:0] s; logic c, o; int e, bb;
        op8(8'h0F, 8'h01, 1'b0, s, c, o, e, bb);
        checks++;
        if ({c, o, s} !== {1'b0, 1'b0, 8'h10}) begin
            fails++;
            $display("FAIL basic_0F_01: got C=%b V=%b S=%h, want C=0 V=0 S=10", c, o, s);
        end
        checks++;
        if (e !== 9) begin
            fails++;
            $display("FAIL latency: got %0d edges, want 9", e);
        end
        checks++;
        if (bb !== 0) begin
            fails++;
            $display("FAIL busy_done_overlap: got %0d cycles, want 0", bb);
        end
    endtask

    task automatic test_hold();
        logic [7:0] s0;
        s0 = S;
        repeat (5) begin
            @(negedge clk);
            A = 8'hEE; B = 8'h77;
        end
        checks++;
        if ({S, Cout, ovf, busy, done} !== {s0, 4'b0000}) begin
            fails++;
            $display("FAIL idle_hold: got S=%h C=%b V=%b busy=%b done=%b, want S=%h 0000",
                     S, Cout, ovf, busy, done, s0);
        end
    endtask

    task automatic test_carry_ovf();
        logic [7:0] s; logic c, o; int e, bb;
        op8(8'hFF, 8'h01, 1'b0, s, c, o, e, bb);
        checks++;
        if ({c, o, s} !== {1'b1, 1'b0, 8'h00}) begin
            fails++;
            $display("FAIL FF_01: got C=%b V=%b S=%h, want C=1 V=0 S=00", c, o, s);
        end
        op8(8'h7F, 8'h01, 1'b0, s, c, o, e, bb);
        checks++;
        if ({c, o, s} !== {1'b0, 1'b1, 8'h80}) begin
            fails++;
            $display("FAIL 7F_01: got C=%b V=%b S=%h, want C=0 V=1 S=80", c, o, s);
        end
        op8(8'hFF, 8'hFF, 1'b1, s, c, o, e, bb);
        checks++;
        if ({c, o, s} !== {1'b1, 1'b0, 8'hFF}) begin
            fails++;
            $display("FAIL FF_FF_ci: got C=%b V=%b S=%h, want C=1 V=0 S=FF", c, o, s);
        end
        op8(8'h80, 8'h80, 1'b0, s, c, o, e, bb);
        checks++;
        if ({c, o, s} !== {1'b1, 1'b1, 8'h00}) begin
            fails++;
            $display("FAIL 80_80: got C=%b V=%b S=%h, want C=1 V=1 S=00", c, o, s);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] s; logic c, o; int e, bb;
        op8(8'h3C, 8'h0A, 1'b1, s, c, o, e, bb);
        checks++;
        if ({c, o, s, e} !== {1'b0, 1'b0, 8'h47, 32'd9}) begin
            fails++;
            $display("FAIL b2b_first: got C=%b V=%b S=%h e=%0d, want C=0 V=0 S=47 e=9",
                     c, o, s, e);
        end
        op8(8'hC8, 8'h64, 1'b0, s, c, o, e, bb);
        checks++;
        if ({c, o, s, e} !== {1'b1, 1'b0, 8'h2C, 32'd9}) begin
            fails++;
            $display("FAIL b2b_second: got C=%b V=%b S=%h e=%0d, want C=1 V=0 S=2C e=9",
                     c, o, s, e);
        end
    endtask

    task automatic test_start_ignored();
        int dn;
        @(negedge clk);
        A = 8'h12; B = 8'h34; Ci = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        A = 8'hFF; B = 8'hFF; Ci = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dn = 0;
        repeat (24) begin
            @(negedge clk);
            if (done) dn++;
        end
        checks++;
        if ({Cout, S} !== {1'b0, 8'h46}) begin
            fails++;
            $display("FAIL start_in_run: got C=%b S=%h, want C=0 S=46", Cout, S);
        end
        checks++;
        if (dn !== 1) begin
            fails++;
            $display("FAIL single_done: got %0d pulses, want 1", dn);
        end
    endtask

    task automatic test_reset_abort();
        logic [7:0] s; logic c, o; int e, bb, dn;
        @(negedge clk);
        A = 8'hAA; B = 8'h55; Ci = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({S, Cout, ovf, busy, done} !== 12'h0) begin
            fails++;
            $display("FAIL reset_abort: got S=%h C=%b V=%b busy=%b done=%b, want all 0",
                     S, Cout, ovf, busy, done);
        end
        @(negedge clk);
        rst = 1'b1;
        dn = 0;
        repeat (14) begin
            @(negedge clk);
            if (done) dn++;
        end
        checks++;
        if (dn !== 0) begin
            fails++;
            $display("FAIL no_done_after_abort: got %0d pulses, want 0", dn);
        end
        op8(8'h01, 8'h02, 1'b0, s, c, o, e, bb);
        checks++;
        if ({c, o, s} !== {1'b0, 1'b0, 8'h03}) begin
            fails++;
            $display("FAIL after_reset_op: got C=%b V=%b S=%h, want C=0 V=0 S=03", c, o, s);
        end
    endtask

    task automatic test_random8();
        logic [7:0] a, b, s; logic ci, c, o; int e, bb, bad;
        logic [8:0] ref_sum; logic ref_v;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom);
            ref_sum = {1'b0, a} + {1'b0, b} + {8'd0, ci};
            ref_v = (a[7] == b[7]) && (ref_sum[7] != a[7]);
            op8(a, b, ci, s, c, o, e, bb);
            checks++;
            if ({c, s, o, e} !== {ref_sum, ref_v, 32'd9}) begin
                fails++;
                if (bad < 5)
                    $display("FAIL rand8 %h+%h+%b: got C=%b S=%h V=%b e=%0d, want %h V=%b",
                             a, b, ci, c, s, o, e, ref_sum, ref_v);
                bad++;
            end
        end
    endtask

    task automatic test_random16();
        logic [15:0] a, b, s; logic ci, c, o; int e, bad;
        logic [16:0] ref_sum; logic ref_v;
        bad = 0;
        for (int i = 0; i < 120; i++) begin
            a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom);
            if (i == 0) begin a = 16'h7FFF; b = 16'h0000; ci = 1'b1; end
            if (i == 1) begin a = 16'hFFFF; b = 16'hFFFF; ci = 1'b1; end
            ref_sum = {1'b0, a} + {1'b0, b} + {16'd0, ci};
            ref_v = (a[15] == b[15]) && (ref_sum[15] != a[15]);
            op16(a, b, ci, s, c, o, e);
            checks++;
            if ({c, s, o, e} !== {ref_sum, ref_v, 32'd17}) begin
                fails++;
                if (bad < 5)
                    $display("FAIL rand16 %h+%h+%b: got C=%b S=%h V=%b e=%0d, want %h V=%b",
                             a, b, ci, c, s, o, e, ref_sum, ref_v);
                bad++;
            end
        end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        test_reset();
        test_basic();
        test_hold();
        test_carry_ovf();
        test_back_to_back();
        test_start_ignored();
        test_reset_abort();
        test_random8();
        test_random16();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
